// File: rtl/seven_seg_capture.sv
// seven_seg_capture: watches a multiplexed, active-low seven-segment bus
// (segments plus anode strobes). It recovers the hex nibble shown on each
// digit once the bus has been stable long enough, and flags blank or illegal
// patterns. It also pulses a frame strobe once every digit has been refreshed.
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    cap_strobe,
    output logic                    frame_valid
);

    // The counter reaches CAP_AT on the last identical sample of a dwell.
    // It then parks at CNT_MAX, so one dwell can never capture twice.
    localparam logic [7:0] CAP_AT    = 8'(STABLE_CYCLES - 2);
    localparam logic [7:0] CNT_MAX   = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Inverse of the hex-to-segment table: {legal, nibble}
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'b0000001: res = {1'b1, 4'h0};
            7'b1001111: res = {1'b1, 4'h1};
            7'b0010010: res = {1'b1, 4'h2};
            7'b0000110: res = {1'b1, 4'h3};
            7'b1001100: res = {1'b1, 4'h4};
            7'b0100100: res = {1'b1, 4'h5};
            7'b0100000: res = {1'b1, 4'h6};
            7'b0001111: res = {1'b1, 4'h7};
            7'b0000000: res = {1'b1, 4'h8};
            7'b0001100: res = {1'b1, 4'h9};
            7'b0001000: res = {1'b1, 4'hA};
            7'b1100000: res = {1'b1, 4'hB};
            7'b0110001: res = {1'b1, 4'hC};
            7'b1000010: res = {1'b1, 4'hD};
            7'b0110000: res = {1'b1, 4'hE};
            7'b0111000: res = {1'b1, 4'hF};
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

    // Input stage (s_*) and its one-cycle-old copy (p_*) used for stability
    logic [NUM_DIGITS-1:0]   s_an_q,   s_an_d;
    logic [6:0]              s_seg_q,  s_seg_d;
    logic [NUM_DIGITS-1:0]   p_an_q,   p_an_d;
    logic [6:0]              p_seg_q,  p_seg_d;
    logic [7:0]              cnt_q,    cnt_d;
    logic [4*NUM_DIGITS-1:0] value_q,  value_d;
    logic [NUM_DIGITS-1:0]   valid_q,  valid_d;
    logic [NUM_DIGITS-1:0]   blank_q,  blank_d;
    logic [NUM_DIGITS-1:0]   err_q,    err_d;
    logic [NUM_DIGITS-1:0]   seen_q,   seen_d;
    logic                    cap_q,    cap_d;
    logic                    frame_q,  frame_d;

    logic [NUM_DIGITS-1:0]   sel;
    logic [NUM_DIGITS-1:0]   seen_next;
    logic [4:0]              dec;
    logic                    scan_legal;
    logic                    same;
    logic                    capture;

    // Stability tracking, decode and capture bookkeeping
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        s_an_d    = an;
        s_seg_d   = seg;
        p_an_d    = s_an_q;
        p_seg_d   = s_seg_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        err_d     = err_q;
        seen_d    = seen_q;
        cap_d     = 1'b0;
        frame_d   = 1'b0;
        seen_next = seen_q;
        dec       = decode_seg(s_seg_q);

        // Exactly one active (low) anode selects a digit; anything else is not a scan.
        sel        = ~s_an_q;
        scan_legal = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
        same       = (s_an_q == p_an_q) && (s_seg_q == p_seg_q);
        capture    = scan_legal && same && (cnt_q == CAP_AT);

        if (!scan_legal || !same) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end

        if (capture) begin
            cap_d = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel[i]) begin
                    if (dec[4]) begin
                        value_d[4*i +: 4] = dec[3:0];
                        valid_d[i]        = 1'b1;
                        blank_d[i]        = 1'b0;
                        err_d[i]          = 1'b0;
                    end else if (s_seg_q == SEG_BLANK) begin
                        valid_d[i] = 1'b0;
                        blank_d[i] = 1'b1;
                        err_d[i]   = 1'b0;
                    end else begin
                        valid_d[i] = 1'b0;
                        blank_d[i] = 1'b0;
                        err_d[i]   = 1'b1;
                    end
                end
            end
            seen_next = seen_q | sel;
            if (seen_next == '1) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seen_next;
            end
        end
    end

    // State registers; reset returns the input stage to an idle (all anodes off) bus
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            s_an_q  <= '1;
            s_seg_q <= '1;
            p_an_q  <= '1;
            p_seg_q <= '1;
            cnt_q   <= '0;
            value_q <= '0;
            valid_q <= '0;
            blank_q <= '0;
            err_q   <= '0;
            seen_q  <= '0;
            cap_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            s_an_q  <= s_an_d;
            s_seg_q <= s_seg_d;
            p_an_q  <= p_an_d;
            p_seg_q <= p_seg_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            cap_q   <= cap_d;
            frame_q <= frame_d;
        end
    end

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign digit_blank = blank_q;
    assign digit_err   = err_q;
    assign cap_strobe  = cap_q;
    assign frame_valid = frame_q;

endmodule
